frame_builder: RTL and testbench
================================

// Module: frame_builder
// PURPOSE
//   Framed test-pattern source on the CLK_USER domain, directly upstream of data_gateway.
//   On a trigger from the gateway it emits one frame of FRAME_LEN 32-bit words: header, incrementing payload, XOR checksum trailer.
//   The host checks frame integrity, loss and ordering through the FT600 link from the header sequence number and the trailer.
// PARAMETERS
//   FRAME_LEN     256        total words per frame incl. header and trailer; legal range 3..65535
//   GAP_CYCLES    4          idle cycles forced after each trailer; 0 allowed
//   HEADER_TAG    16'hA55A   upper half of every header word
//   PAYLOAD_SEED  32'h0      payload counter value after reset
// PORTS
//   clk_in         in   1    user clock (CLK_USER, 27 MHz)
//   rst_in         in   1    asynchronous reset, active-low
//   enable_in      in   1    1 = frames may start; sampled only in IDLE
//   trigger_in     in   1    gateway request (level): room for one full frame
//   data_out       out  32   frame word; 0 when valid_out = 0
//   valid_out      out  1    data_out holds a frame word this cycle
//   sof_out        out  1    high with the header word
//   eof_out        out  1    high with the trailer word
//   busy_out       out  1    high in HEADER, PAYLOAD, TRAILER and GAP
//   frame_cnt_out  out  16   completed frames; equals next header sequence number
// BEHAVIOUR
//   - Outputs: all registered, no combinational path from inputs.
//   - Reset: async assert, sync release. All outputs 0; seq = 0; payload counter = PAYLOAD_SEED; state IDLE.
//   - FSM states: IDLE, HEADER, PAYLOAD, TRAILER, GAP.
//   - IDLE -> HEADER: when enable_in and trigger_in are both high at a clock edge. The header word is on the outputs the following cycle.
//   - HEADER: data = {HEADER_TAG, seq}; valid = 1; sof = 1. Checksum register loaded with the header word.
//   - PAYLOAD: FRAME_LEN-2 consecutive cycles, valid = 1.
//     - Each word = payload counter; counter += 1 mod 2^32 per word.
//     - Counter carries across frames and is never reset except by rst_in.
//     - Checksum ^= word.
//   - TRAILER: data = checksum (XOR of header and all payload words); valid = 1; eof = 1.
//     - seq += 1 mod 2^16; frame_cnt_out updates the same cycle the trailer is driven.
//   - GAP: GAP_CYCLES cycles with valid = 0, then IDLE. If GAP_CYCLES = 0, TRAILER -> IDLE directly.
//   - Frame spacing: valid words are strictly back-to-back inside a frame. With trailer at cycle t and trigger held high, the next header is at t+GAP_CYCLES+2 (one IDLE cycle).
//   - Once HEADER is entered the frame always completes. Drops of trigger_in or enable_in mid-frame or in GAP are ignored; they are sampled only in IDLE.
//   - Flow control: no backpressure. data_gateway asserts trigger_in only when it can absorb FRAME_LEN words.
//   - Reset mid-frame: frame is truncated, no trailer. Outputs drop to 0 immediately; seq and counter restart as after reset.
//   - Wrap-around: seq 16'hFFFF -> 0 and counter 32'hFFFFFFFF -> 0 are silent, with no status flag.
// TESTING
//   1. Reset, then hold rst_in=0 with trigger_in=1 -> all outputs 0, busy_out=0. Release -> no output until enable_in=1.
//   2. FRAME_LEN=4, GAP=0, seed 0, one trigger -> words A55A0000, 0, 1, A55A0001.
//      - sof on word 1, eof on word 4; frame_cnt_out=1.
//   3. Same config, trigger held -> second frame A55A0001, 2, 3, A55A0000.
//      - Its header comes 2 cycles after the first trailer (one IDLE cycle).
//   4. GAP_CYCLES=4, trigger held -> exactly 5 invalid cycles between trailer and next header.
//      - busy_out low only in the IDLE cycle.
//   5. Deassert trigger_in and enable_in after the header (FRAME_LEN=256) -> all 256 words still emitted.
//      - No new frame starts.
//   6. PAYLOAD_SEED=32'hFFFFFFFE, FRAME_LEN=5 -> payload FFFFFFFE, FFFFFFFF, 0; trailer = A55A0000^1 = A55A0001.
//      - Assert rst_in low mid-payload -> valid_out=0 immediately; next frame header A55A0000.

Source files
------------

// File: rtl/frame_builder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : frame_builder_if
//  Description : Control and frame-output bundle of frame_builder.
//                master = frame source (frame_builder)
//                slave  = frame consumer / controller (data_gateway side)
//  Signals     : enable_in      1  frames may start (sampled only in IDLE)
//                trigger_in     1  request: room for one full frame (level)
//                data_out      32  frame word, 0 when valid_out = 0
//                valid_out      1  data_out holds a frame word
//                sof_out        1  header word marker
//                eof_out        1  trailer word marker
//                busy_out       1  frame or inter-frame gap in progress
//                frame_cnt_out 16  completed frames / next sequence number
//  Revision    : 1.0  initial release
// ============================================================================
interface frame_builder_if;
    logic        enable_in;
    logic        trigger_in;
    logic [31:0] data_out;
    logic        valid_out;
    logic        sof_out;
    logic        eof_out;
    logic        busy_out;
    logic [15:0] frame_cnt_out;

    modport master (
        input  enable_in,
        input  trigger_in,
        output data_out,
        output valid_out,
        output sof_out,
        output eof_out,
        output busy_out,
        output frame_cnt_out
    );

    modport slave (
        output enable_in,
        output trigger_in,
        input  data_out,
        input  valid_out,
        input  sof_out,
        input  eof_out,
        input  busy_out,
        input  frame_cnt_out
    );
endinterface
`default_nettype wire

// File: rtl/frame_builder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : frame_builder
//  Description : Framed test-pattern source. On trigger (with enable) emits
//                one frame of FRAME_LEN 32-bit words: header {TAG, seq},
//                FRAME_LEN-2 incrementing payload words, XOR checksum
//                trailer; then GAP_CYCLES idle cycles. All outputs are
//                registered.
//  Ports       : clk_in   user clock
//                rst_in   asynchronous reset, active-low
//                bus      frame_builder_if.master (enable/trigger in,
//                         data/valid/sof/eof/busy/frame_cnt out)
//  Revision    : 1.0  initial release
// ============================================================================
module frame_builder #(
    parameter int          FRAME_LEN    = 256,
    parameter int          GAP_CYCLES   = 4,
    parameter logic [15:0] HEADER_TAG   = 16'hA55A,
    parameter logic [31:0] PAYLOAD_SEED = 32'h0
) (
    input  wire logic             clk_in,
    input  wire logic             rst_in,
    frame_builder_if.master       bus
);

    // Index of the last payload word and of the last gap cycle.
    localparam logic [15:0] C_PAY_LAST = 16'(FRAME_LEN - 2);
    localparam logic [31:0] C_GAP_LAST = 32'(GAP_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_HEADER  = 3'd1,
        S_PAYLOAD = 3'd2,
        S_TRAILER = 3'd3,
        S_GAP     = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Reset: asserts asynchronously, releases on a clock edge after two
    // flops so the whole block leaves reset in the same cycle.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       rst_sync_n;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_sync_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // State. state_q names the state whose word is on the outputs now;
    // the output registers are loaded from the next-state decode so the
    // outputs and state always change together.
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic [15:0] seq_q,   seq_d;
    logic [31:0] cnt_q,   cnt_d;
    logic [31:0] csum_q,  csum_d;
    logic [15:0] beat_q,  beat_d;   // payload words already emitted
    logic [31:0] gap_q,   gap_d;    // gap cycles already emitted
    logic [31:0] data_q,  data_d;
    logic        valid_q, valid_d;
    logic        sof_q,   sof_d;
    logic        eof_q,   eof_d;
    logic        busy_q,  busy_d;

    always_ff @(posedge clk_in or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state_q <= S_IDLE;
            seq_q   <= 16'h0000;
            cnt_q   <= PAYLOAD_SEED;
            csum_q  <= 32'h0;
            beat_q  <= 16'h0000;
            gap_q   <= 32'h0;
            data_q  <= 32'h0;
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            cnt_q   <= cnt_d;
            csum_q  <= csum_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        cnt_d   = cnt_q;
        csum_d  = csum_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        data_d  = 32'h0;
        valid_d = 1'b0;
        sof_d   = 1'b0;
        eof_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // enable/trigger are only looked at here; a started frame
                // always runs to completion.
                if (bus.enable_in && bus.trigger_in) begin
                    state_d = S_HEADER;
                    data_d  = {HEADER_TAG, seq_q};
                    valid_d = 1'b1;
                    sof_d   = 1'b1;
                    csum_d  = {HEADER_TAG, seq_q};
                end
            end

            S_HEADER: begin
                state_d = S_PAYLOAD;
                data_d  = cnt_q;
                valid_d = 1'b1;
                csum_d  = csum_q ^ cnt_q;
                cnt_d   = cnt_q + 32'd1;
                beat_d  = 16'd1;
            end

            S_PAYLOAD: begin
                valid_d = 1'b1;
                if (beat_q == C_PAY_LAST) begin
                    state_d = S_TRAILER;
                    data_d  = csum_q;
                    eof_d   = 1'b1;
                    seq_d   = seq_q + 16'd1;
                end else begin
                    data_d  = cnt_q;
                    csum_d  = csum_q ^ cnt_q;
                    cnt_d   = cnt_q + 32'd1;
                    beat_d  = beat_q + 16'd1;
                end
            end

            S_TRAILER: begin
                if (GAP_CYCLES == 0) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_GAP;
                    gap_d   = 32'd1;
                end
            end

            S_GAP: begin
                if (gap_q == C_GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d   = gap_q + 32'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    assign bus.data_out      = data_q;
    assign bus.valid_out     = valid_q;
    assign bus.sof_out       = sof_q;
    assign bus.eof_out       = eof_q;
    assign bus.busy_out      = busy_q;
    // The sequence register advances on the trailer edge, so it doubles as
    // the completed-frame count.
    assign bus.frame_cnt_out = seq_q;

endmodule
`default_nettype wire

// File: tb/tb_frame_builder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_frame_builder
//  Description : Self-checking bench for frame_builder. Four instances with
//                different parameter sets; expected words are pushed to a
//                per-instance queue and popped as valid words appear.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_frame_builder;

    localparam int NDUT = 4;

    logic       clk = 1'b0;
    logic [3:0] rst_n;

    always #5 clk = ~clk;

    frame_builder_if bus0();
    frame_builder_if bus1();
    frame_builder_if bus2();
    frame_builder_if bus3();

    frame_builder #(.FRAME_LEN(4),   .GAP_CYCLES(0)) u0 (.clk_in(clk), .rst_in(rst_n[0]), .bus(bus0.master));
    frame_builder #(.FRAME_LEN(4),   .GAP_CYCLES(4)) u1 (.clk_in(clk), .rst_in(rst_n[1]), .bus(bus1.master));
    frame_builder #(.FRAME_LEN(256), .GAP_CYCLES(4)) u2 (.clk_in(clk), .rst_in(rst_n[2]), .bus(bus2.master));
    frame_builder #(.FRAME_LEN(5),   .GAP_CYCLES(0), .PAYLOAD_SEED(32'hFFFFFFFE))
                  u3 (.clk_in(clk), .rst_in(rst_n[3]), .bus(bus3.master));

    logic [31:0] dat [NDUT];
    logic        vld [NDUT];
    logic        sof [NDUT];
    logic        eof [NDUT];
    logic        bsy [NDUT];
    logic [15:0] fcn [NDUT];

    always_comb begin
        dat[0] = bus0.data_out; vld[0] = bus0.valid_out; sof[0] = bus0.sof_out;
        eof[0] = bus0.eof_out;  bsy[0] = bus0.busy_out;  fcn[0] = bus0.frame_cnt_out;
        dat[1] = bus1.data_out; vld[1] = bus1.valid_out; sof[1] = bus1.sof_out;
        eof[1] = bus1.eof_out;  bsy[1] = bus1.busy_out;  fcn[1] = bus1.frame_cnt_out;
        dat[2] = bus2.data_out; vld[2] = bus2.valid_out; sof[2] = bus2.sof_out;
        eof[2] = bus2.eof_out;  bsy[2] = bus2.busy_out;  fcn[2] = bus2.frame_cnt_out;
        dat[3] = bus3.data_out; vld[3] = bus3.valid_out; sof[3] = bus3.sof_out;
        eof[3] = bus3.eof_out;  bsy[3] = bus3.busy_out;  fcn[3] = bus3.frame_cnt_out;
    end

    // Scoreboard entry: {sof, eof, data}
    logic [33:0] exp_q [NDUT][$];
    logic [15:0] m_seq [NDUT];
    logic [31:0] m_cnt [NDUT];
    int          sof_cyc [NDUT];
    int          eof_cyc [NDUT];
    int          vcnt [NDUT];
    int          total;
    int          bad;
    int          cyc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
        total++;
        assert (obs === req) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, req);
        end
    endtask

    // Expected words of one complete frame from the reference model.
    task automatic push_frame(input int k, input int len);
        logic [31:0] cs;
        cs = {16'hA55A, m_seq[k]};
        exp_q[k].push_back({2'b10, cs});
        for (int i = 0; i < len - 2; i++) begin
            exp_q[k].push_back({2'b00, m_cnt[k]});
            cs = cs ^ m_cnt[k];
            m_cnt[k] = m_cnt[k] + 32'd1;
        end
        exp_q[k].push_back({2'b01, cs});
        m_seq[k] = m_seq[k] + 16'd1;
    endtask

    // Advance one cycle and check every instance's outputs on the falling edge.
    task automatic tick();
        logic [33:0] e;
        @(negedge clk);
        cyc++;
        for (int k = 0; k < NDUT; k++) begin
            if (vld[k]) begin
                vcnt[k]++;
                if (sof[k]) sof_cyc[k] = cyc;
                if (eof[k]) eof_cyc[k] = cyc;
                if (exp_q[k].size() == 0) begin
                    chk($sformatf("unexpected_word_dut%0d", k), 64'(exp_q[k].size()), 64'd1);
                end else begin
                    e = exp_q[k].pop_front();
                    chk($sformatf("word_dut%0d", k), 64'({sof[k], eof[k], dat[k]}), 64'(e));
                end
            end else begin
                chk($sformatf("idle_zero_dut%0d", k), 64'({sof[k], eof[k], dat[k]}), 64'd0);
            end
        end
    endtask

    task automatic wait_flag(input int k, input bit want_eof, input int budget);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < budget && !seen; n++) begin
            tick();
            if (vld[k] && (want_eof ? eof[k] : sof[k])) seen = 1'b1;
        end
        chk($sformatf("wait_%s_dut%0d", want_eof ? "eof" : "sof", k), 64'(seen), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int t1;
        int inv;
        int idle;
        int vstart;
        total = 0; bad = 0; cyc = 0;
        for (int k = 0; k < NDUT; k++) begin
            m_seq[k] = 16'h0; m_cnt[k] = 32'h0;
            sof_cyc[k] = 0; eof_cyc[k] = 0; vcnt[k] = 0;
        end
        m_cnt[3] = 32'hFFFFFFFE;
        rst_n = 4'h0;
        bus0.enable_in = 1'b0; bus0.trigger_in = 1'b0;
        bus1.enable_in = 1'b0; bus1.trigger_in = 1'b0;
        bus2.enable_in = 1'b0; bus2.trigger_in = 1'b0;
        bus3.enable_in = 1'b0; bus3.trigger_in = 1'b0;

        // Reset held with trigger high: everything quiet.
        bus0.trigger_in = 1'b1;
        repeat (3) tick();
        chk("reset_outputs", 64'({vld[0], sof[0], eof[0], bsy[0], fcn[0], dat[0]}), 64'd0);
        rst_n = 4'hF;
        repeat (6) tick();
        chk("no_enable_busy", 64'(bsy[0]), 64'd0);
        chk("no_enable_fcnt", 64'(fcn[0]), 64'd0);

        // Single frame, FRAME_LEN=4, GAP=0.
        push_frame(0, 4);
        bus0.enable_in = 1'b1;
        tick();
        chk("first_header", 64'(dat[0]), 64'hA55A0000);
        bus0.trigger_in = 1'b0;
        repeat (6) tick();
        chk("fcnt_after_one", 64'(fcn[0]), 64'd1);
        chk("frame_span", 64'(eof_cyc[0] - sof_cyc[0]), 64'd3);

        // Trigger held: header two cycles after previous trailer.
        push_frame(0, 4);
        push_frame(0, 4);
        bus0.trigger_in = 1'b1;
        wait_flag(0, 1'b1, 20);
        t1 = eof_cyc[0];
        wait_flag(0, 1'b0, 20);
        bus0.trigger_in = 1'b0;
        chk("hdr_spacing_gap0", 64'(sof_cyc[0] - t1), 64'd2);
        repeat (8) tick();
        chk("fcnt_after_three", 64'(fcn[0]), 64'd3);

        // GAP_CYCLES=4: five invalid cycles, busy low only in the IDLE one.
        push_frame(1, 4);
        push_frame(1, 4);
        bus1.enable_in = 1'b1; bus1.trigger_in = 1'b1;
        wait_flag(1, 1'b1, 20);
        t1 = eof_cyc[1];
        inv = 0; idle = 0;
        for (int n = 0; n < 20; n++) begin
            tick();
            if (vld[1] && sof[1]) break;
            if (!vld[1]) inv++;
            if (!bsy[1]) idle++;
        end
        bus1.trigger_in = 1'b0;
        chk("gap4_invalid_cycles", 64'(inv), 64'd5);
        chk("gap4_busy_low_cycles", 64'(idle), 64'd1);
        chk("hdr_spacing_gap4", 64'(sof_cyc[1] - t1), 64'd6);
        repeat (8) tick();
        chk("fcnt_gap4", 64'(fcn[1]), 64'd2);

        // Drop enable and trigger right after the header: frame completes.
        push_frame(2, 256);
        vstart = vcnt[2];
        bus2.enable_in = 1'b1; bus2.trigger_in = 1'b1;
        wait_flag(2, 1'b0, 10);
        bus2.enable_in = 1'b0; bus2.trigger_in = 1'b0;
        repeat (300) tick();
        chk("long_frame_words", 64'(vcnt[2] - vstart), 64'd256);
        chk("long_frame_fcnt", 64'(fcn[2]), 64'd1);
        chk("long_frame_not_busy", 64'(bsy[2]), 64'd0);

        // Payload counter wrap.
        push_frame(3, 5);
        bus3.enable_in = 1'b1; bus3.trigger_in = 1'b1;
        wait_flag(3, 1'b0, 10);
        bus3.trigger_in = 1'b0;
        wait_flag(3, 1'b1, 10);
        chk("wrap_trailer", 64'(dat[3]), 64'hA55A0001);
        repeat (2) tick();

        // Reset in the middle of the payload.
        exp_q[3].push_back({2'b10, 32'hA55A0001});
        exp_q[3].push_back({2'b00, 32'h00000001});
        exp_q[3].push_back({2'b00, 32'h00000002});
        bus3.trigger_in = 1'b1;
        tick();
        bus3.trigger_in = 1'b0;
        repeat (2) tick();
        rst_n[3] = 1'b0;
        #1;
        chk("reset_immediate", 64'({vld[3], sof[3], eof[3], bsy[3], fcn[3], dat[3]}), 64'd0);
        m_seq[3] = 16'h0;
        m_cnt[3] = 32'hFFFFFFFE;
        repeat (3) tick();
        rst_n[3] = 1'b1;
        repeat (3) tick();
        push_frame(3, 5);
        bus3.trigger_in = 1'b1;
        wait_flag(3, 1'b0, 10);
        bus3.trigger_in = 1'b0;
        chk("hdr_after_reset", 64'(dat[3]), 64'hA55A0000);
        wait_flag(3, 1'b1, 10);
        repeat (2) tick();

        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("queue_drained_dut%0d", k), 64'(exp_q[k].size()), 64'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
